// File: rtl/post_adder_stage.sv
`default_nettype none
// ============================================================================
// post_adder_stage: 48-bit post add/subtract with P/CARRYOUT registers and a
// sticky signed-overflow flag. Optional compare: DSP_PATTERN_DETECT_EN.
// Revision: 1.0
// ============================================================================
module post_adder_stage #(
  parameter int          PREG        = 1,
  parameter int          CARRYOUTREG = 1,
  parameter logic [47:0] PATTERN     = 48'h0,
  parameter logic [47:0] MASK        = 48'h0
) (
  input  logic        clk,
  input  logic        RSTP,
  input  logic        CEP,
  input  logic        CECARRYOUT,
  input  logic [47:0] outOfX,
  input  logic [47:0] outOfZ,
  input  logic        outOfCYI,
  input  logic [7:0]  opmode,
  input  logic        in_valid,
  input  logic        clr_ovf,
  output logic [47:0] P,
  output logic [47:0] PCOUT,
  output logic        CARRYOUT,
  output logic        CARRYOUTF,
  output logic        out_valid,
  output logic        ovf
`ifdef DSP_PATTERN_DETECT_EN
  ,
  output logic        patterndetect
`endif
);

  logic        w_sub;
  logic [48:0] w_x_cy;
  logic [48:0] w_res;
  logic [47:0] w_r;
  logic        w_c;
  logic        w_v;
  logic        w_ovf_en;
  logic        r_ovf;

  // Folding CYI into X first makes bit 48 the carry on add and the borrow on subtract.
  assign w_sub  = opmode[7];
  assign w_x_cy = {1'b0, outOfX} + {48'd0, outOfCYI};
  assign w_res  = w_sub ? ({1'b0, outOfZ} - w_x_cy) : ({1'b0, outOfZ} + w_x_cy);
  assign w_r    = w_res[47:0];
  assign w_c    = w_res[48];
  assign w_v    = (w_sub ? (outOfX[47] != outOfZ[47]) : (outOfX[47] == outOfZ[47]))
                  && (w_r[47] != outOfZ[47]);

  assign w_ovf_en = (PREG != 0) ? CEP : 1'b1;

  // Set has priority over clear.
  always_ff @(posedge clk or posedge RSTP) begin
    if (RSTP) begin
      r_ovf <= 1'b0;
    end else if (w_ovf_en) begin
      if (in_valid && w_v) begin
        r_ovf <= 1'b1;
      end else if (clr_ovf) begin
        r_ovf <= 1'b0;
      end
    end
  end

  assign ovf = r_ovf;

  generate
    if (PREG != 0) begin : g_preg
      logic [47:0] r_p;
      logic        r_valid;
      always_ff @(posedge clk or posedge RSTP) begin
        if (RSTP) begin
          r_p     <= 48'd0;
          r_valid <= 1'b0;
        end else if (CEP) begin
          r_p     <= w_r;
          r_valid <= in_valid;
        end
      end
      assign P         = r_p;
      assign out_valid = r_valid;
    end else begin : g_pcomb
      assign P         = w_r;
      assign out_valid = in_valid;
    end
  endgenerate

  assign PCOUT = P;

  generate
    if (CARRYOUTREG != 0) begin : g_coreg
      logic r_co;
      always_ff @(posedge clk or posedge RSTP) begin
        if (RSTP) begin
          r_co <= 1'b0;
        end else if (CECARRYOUT) begin
          r_co <= w_c;
        end
      end
      assign CARRYOUT = r_co;
    end else begin : g_cocomb
      assign CARRYOUT = w_c;
    end
  endgenerate

  assign CARRYOUTF = CARRYOUT;

`ifdef DSP_PATTERN_DETECT_EN
  logic w_pd;
  assign w_pd = (((w_r ^ PATTERN) & ~MASK) == 48'd0);

  generate
    if (PREG != 0) begin : g_pd_reg
      logic r_pd;
      always_ff @(posedge clk or posedge RSTP) begin
        if (RSTP) begin
          r_pd <= 1'b0;
        end else if (CEP) begin
          r_pd <= w_pd;
        end
      end
      assign patterndetect = r_pd;
    end else begin : g_pd_comb
      assign patterndetect = w_pd;
    end
  endgenerate

  logic w_unused_ok;
  assign w_unused_ok = ^{opmode[6:0], CEP, CECARRYOUT};
`else
  logic w_unused_ok;
  assign w_unused_ok = ^{opmode[6:0], CEP, CECARRYOUT, PATTERN, MASK};
`endif

endmodule
`default_nettype wire
